mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares one single-port synchronous data RAM (1-cycle read latency, byte-lane write enables) between two requesters.
- Requester 0 is the instruction-side read port (read-only). Requester 1 is the execution-stage load/store port.
- Sits between the core pipeline and the RAM. It issues at most one RAM access per cycle, routes read data back to the owning requester, and raises a stall request to the pipeline when an access is denied.

Parameters:
- ADDR_W, 32, address width for both requesters and the RAM.
- DATA_W, 32, data width. Must be a multiple of 8.
- STARVE_LIMIT, 4, number of consecutive denied cycles of requester 0 after which requester 0 wins the next arbitration. Legal range 1..15.

Ports:
- sys_clk  in  1  clock; all state updates on the rising edge
- sys_rst_n  in  1  asynchronous active-low reset
- m0_req  in  1  requester 0 read request
- m0_addr  in  ADDR_W  requester 0 address
- m0_gnt  out  1  requester 0 granted this cycle
- m0_rvalid  out  1  requester 0 read data valid
- m0_rdata  out  DATA_W  requester 0 read data
- m1_req  in  1  requester 1 request
- m1_we  in  DATA_W/8  byte write enables; 0 = read
- m1_addr  in  ADDR_W  requester 1 address
- m1_wdata  in  DATA_W  requester 1 write data
- m1_gnt  out  1  requester 1 granted this cycle
- m1_rvalid  out  1  requester 1 read data valid
- m1_rdata  out  DATA_W  requester 1 read data
- ram_ren  out  1  RAM read enable
- ram_wen  out  DATA_W/8  RAM byte write enables
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_ren
- stall_req  out  1  pipeline stall request = (m0_req & ~m0_gnt) | (m1_req & ~m1_gnt)

Behaviour:
Grants
- m0_gnt and m1_gnt are combinational from the requests and the registered arbitration state. They are mutually exclusive.
- Both grants are forced to 0 while sys_rst_n is low.

Handshake
- A requester holds req, addr, we and wdata stable until its grant is seen.
- The access is issued to the RAM in the grant cycle, and the request is consumed in that cycle.
- A requester that keeps req high after its grant makes a new request, so back-to-back accesses are allowed.

RAM drive
- For the granted requester: ram_addr and ram_wdata are taken from that requester.
- ram_ren = 1 for an m0 grant, or for an m1 grant with m1_we == 0.
- ram_wen = m1_we on an m1 grant.
- With no grant: ram_ren = 0, ram_wen = 0, ram_addr = 0, ram_wdata = 0.

Arbitration (default)
- Fixed priority: m1 over m0.
- starve_cnt (4-bit register, reset 0):
  - increments on each cycle with m0_req & ~m0_gnt, saturating at 15;
  - clears on an m0 grant, or on any cycle with m0_req = 0.
- When starve_cnt >= STARVE_LIMIT and both requesters request, m0 wins.

Read return
- Registered state resp_owner (2 bits: none/m0/m1, reset none) is captured from the read grant each cycle.
- The cycle after a read grant: the matching mN_rvalid = 1 and mN_rdata = ram_rdata.
- Otherwise mN_rvalid = 0 and mN_rdata = 0.
- Writes produce no rvalid.
- Read latency is exactly 1 cycle from grant. Full throughput: one access per cycle.

Reset
- Reset values: m0_rvalid = 0, m1_rvalid = 0, m0_rdata = 0, m1_rdata = 0, resp_owner = none, starve_cnt = 0, stall_req = 0.
- Reset asserted while a read is in flight: the read response is discarded, and no rvalid is produced after reset release.

Boundary conditions
- Simultaneous m1 write and m0 read: the write is granted and m0 waits, unless the starvation override applies.
- A same-address read immediately after a write returns the new data; RAM write-first ordering is relied upon.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: fixed priority and starve_cnt are removed. A 1-bit last_winner register (reset = m1) gives priority to the requester that did not win most recently. Priority toggles only on cycles where both requesters request.
- Undefined: fixed priority with starvation override, as described under Behaviour.

Test Plan:
- Reset release; m0_req = 1, m0_addr = 0x10, m1_req = 0 -> m0_gnt = 1 the same cycle; ram_ren = 1 and ram_addr = 0x10; next cycle m0_rvalid = 1 and m0_rdata = RAM[0x10].
- m1 write m1_we = 4'b0011, m1_addr = 0x20, m1_wdata = 0xAABBCCDD, then an m1 read of 0x20 -> ram_wen = 4'b0011 on the first grant, no rvalid for the write; the read returns with the upper bytes of the old word unchanged and the low half = 0xCCDD.
- m0_req and m1_req both held high continuously, STARVE_LIMIT = 4 -> grants follow m1, m1, m1, m1, m0 repeating; stall_req = 1 on every cycle.
- Back-to-back m1 reads of 0x0, 0x4, 0x8 -> three consecutive m1_gnt cycles; m1_rvalid high for three consecutive cycles with data in order.
- m0 read granted, then sys_rst_n pulled low mid-cycle before the return -> m0_rvalid stays 0; all outputs at reset values; after release, the first new request behaves normally.
- With MEM_ARB_ROUND_ROBIN_EN defined and both requesting continuously -> grants alternate m0, m1, m0, m1 starting with m0.

Source files
------------

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Shares one single-port synchronous RAM between two requesters. The RAM
//   has a 1-cycle read latency and byte-lane write enables.
//   - Requester 0 is the instruction-side read port (read-only).
//   - Requester 1 is the execution-stage load/store port.
//   At most one RAM access is issued per cycle. Read data is routed back to
//   the requester that issued the read. A stall request is raised whenever
//   an access is denied.
//
// Arbitration:
//   Default build: requester 1 has fixed priority. If requester 0 has been
//   denied STARVE_LIMIT consecutive cycles, it wins the next contended cycle.
//   With MEM_ARB_ROUND_ROBIN_EN defined, contended cycles alternate between
//   the requesters. A last-winner register starts at requester 1, so
//   requester 0 wins the first contended cycle.
//
// Ports:
//   sys_clk, sys_rst_n          clock, asynchronous active-low reset
//   m0_req/m0_addr              requester 0 read request
//   m0_gnt/m0_rvalid/m0_rdata   requester 0 grant and read return
//   m1_req/m1_we/m1_addr/m1_wdata  requester 1 request (m1_we == 0 is a read)
//   m1_gnt/m1_rvalid/m1_rdata   requester 1 grant and read return
//   ram_ren/ram_wen/ram_addr/ram_wdata/ram_rdata  RAM port
//   stall_req                   an access is being denied this cycle
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  m0_req,
    input  logic [ADDR_W-1:0]     m0_addr,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_W-1:0]     m0_rdata,
    input  logic                  m1_req,
    input  logic [DATA_W/8-1:0]   m1_we,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [DATA_W-1:0]     m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_W-1:0]     m1_rdata,
    output logic                  ram_ren,
    output logic [DATA_W/8-1:0]   ram_wen,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    input  logic [DATA_W-1:0]     ram_rdata,
    output logic                  stall_req
);

    localparam int NB = DATA_W / 8;

    localparam logic [1:0] OWNER_NONE = 2'd0;
    localparam logic [1:0] OWNER_M0   = 2'd1;
    localparam logic [1:0] OWNER_M1   = 2'd2;

    logic [1:0] resp_owner_reg;
    logic [1:0] resp_owner_next;
    logic       m0_wins;   // who takes a contended cycle
    logic       m1_read;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // 1 = requester 1 won the last contended cycle, so requester 0 goes next.
    logic last_winner_reg;
    logic last_winner_next;

    assign m0_wins = last_winner_reg;

    always_comb begin
        last_winner_next = last_winner_reg;
        if (m0_req && m1_req) begin
            last_winner_next = m1_gnt;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            last_winner_reg <= 1'b1;
        end else begin
            last_winner_reg <= last_winner_next;
        end
    end
`else
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_reg;
    logic [3:0] starve_cnt_next;

    assign m0_wins = (starve_cnt_reg >= LIMIT);

    // The count tracks consecutive denied cycles of requester 0. It
    // saturates so that a long starvation cannot wrap back below the limit.
    always_comb begin
        starve_cnt_next = 4'd0;
        if (m0_req && !m0_gnt) begin
            starve_cnt_next = (starve_cnt_reg == 4'hF) ? starve_cnt_reg
                                                       : starve_cnt_reg + 4'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            starve_cnt_reg <= 4'd0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
        end
    end
`endif

    // Grants are mutually exclusive. On a contended cycle, m0_wins selects
    // exactly one requester. Both grants are held low during reset.
    assign m0_gnt = sys_rst_n & m0_req & (~m1_req | m0_wins);
    assign m1_gnt = sys_rst_n & m1_req & ~(m0_req & m0_wins);

    assign m1_read   = m1_gnt & (m1_we == '0);
    assign ram_ren   = m0_gnt | m1_read;
    assign ram_addr  = m0_gnt ? m0_addr : (m1_gnt ? m1_addr : '0);
    assign stall_req = sys_rst_n & ((m0_req & ~m0_gnt) | (m1_req & ~m1_gnt));

    // Only requester 1 can write, so the write lanes come from requester 1.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign ram_wen[gi]             = m1_gnt & m1_we[gi];
            assign ram_wdata[gi*8 +: 8]    = m1_gnt ? m1_wdata[gi*8 +: 8] : 8'h00;
        end
    endgenerate

    // Record which requester owns the RAM output on the next cycle.
    always_comb begin
        resp_owner_next = OWNER_NONE;
        if (m0_gnt) begin
            resp_owner_next = OWNER_M0;
        end else if (m1_read) begin
            resp_owner_next = OWNER_M1;
        end
    end

    // Reset clears the owner, which discards any read that is in flight.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            resp_owner_reg <= OWNER_NONE;
        end else begin
            resp_owner_reg <= resp_owner_next;
        end
    end

    assign m0_rvalid = (resp_owner_reg == OWNER_M0);
    assign m1_rvalid = (resp_owner_reg == OWNER_M1);
    assign m0_rdata  = m0_rvalid ? ram_rdata : '0;
    assign m1_rdata  = m1_rvalid ? ram_rdata : '0;

endmodule
